// File: rtl/wb_bus_arbiter.sv
// Two-master (RW priority, RO anti-starvation) to one-slave pipelined Wishbone arbiter
// with an outstanding-strobe limit and a no-ack watchdog that aborts hung cycles.
module wb_bus_arbiter #(
    parameter int AW      = 32,
    parameter int MW      = 64,
    parameter int BW      = MW / 8,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_a_cyc,
    input  logic          i_a_stb,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [MW-1:0] i_a_data,
    input  logic [BW-1:0] i_a_be,
    output logic          o_a_ack,
    output logic          o_a_stall,
    output logic          o_a_err,
    output logic [MW-1:0] o_a_data,
    input  logic          i_b_cyc,
    input  logic          i_b_stb,
    input  logic [AW-1:0] i_b_addr,
    output logic          o_b_ack,
    output logic          o_b_stall,
    output logic          o_b_err,
    output logic [MW-1:0] o_b_data,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [MW-1:0] o_wb_data,
    output logic [BW-1:0] o_wb_be,
    input  logic          i_wb_ack,
    input  logic          i_wb_stall,
    input  logic          i_wb_err,
    input  logic [MW-1:0] i_wb_data,
    output logic [1:0]    o_grant
);

    // State encoding equals the grant code, so o_grant doubles as the FSM debug view.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT_A = 2'b01,
        ST_GRANT_B = 2'b10
    } state_t;

    localparam logic [3:0]  MAX_OUT_C = 4'(MAX_OUT);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    state_t      state, state_next;
    logic [3:0]  outstanding, outstanding_next;
    logic [15:0] watchdog, watchdog_next;
    logic        ro_waited, ro_waited_next;

    logic owner_cyc, owner_stb, granted, wd_expired, abort;
    logic out_full, ack_valid, wb_cyc, wb_stb, stb_accept;

    // Handshake: stb is valid, !stall is ready; a strobe transfers in any cycle with
    // stb && !stall, on both the master side and the downstream side.
    always_comb begin
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        case (state)
            ST_GRANT_A: begin owner_cyc = i_a_cyc; owner_stb = i_a_stb; end
            ST_GRANT_B: begin owner_cyc = i_b_cyc; owner_stb = i_b_stb; end
            default:    begin owner_cyc = 1'b0;    owner_stb = 1'b0;    end
        endcase
    end

    assign granted    = (state != ST_IDLE);
    assign wd_expired = granted && (watchdog >= TIMEOUT_C);
    assign abort      = granted && (i_wb_err || wd_expired);
    assign out_full   = (outstanding >= MAX_OUT_C);
    assign ack_valid  = i_wb_ack && (outstanding != 4'd0);
    assign wb_cyc     = owner_cyc && !abort;
    assign wb_stb     = owner_stb && wb_cyc && !out_full;
    assign stb_accept = wb_stb && !i_wb_stall;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            outstanding <= 4'd0;
            watchdog    <= 16'd0;
            ro_waited   <= 1'b0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            watchdog    <= watchdog_next;
            ro_waited   <= ro_waited_next;
        end
    end

    always_comb begin
        state_next       = state;
        ro_waited_next   = ro_waited;
        outstanding_next = outstanding;
        watchdog_next    = watchdog;
        case (state)
            ST_IDLE: begin
                if (i_a_cyc && i_b_cyc) state_next = ro_waited ? ST_GRANT_B : ST_GRANT_A;
                else if (i_a_cyc)       state_next = ST_GRANT_A;
                else if (i_b_cyc)       state_next = ST_GRANT_B;
            end
            ST_GRANT_A: begin
                if (i_b_cyc) ro_waited_next = 1'b1;
                if (abort || !i_a_cyc) state_next = ST_IDLE;
            end
            ST_GRANT_B: begin
                if (abort || !i_b_cyc) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (state != ST_GRANT_B && state_next == ST_GRANT_B) ro_waited_next = 1'b0;

        // Leaving a tenure for any reason discards whatever is still in flight.
        if (state_next == ST_IDLE) begin
            outstanding_next = 4'd0;
            watchdog_next    = 16'd0;
        end else begin
            if (stb_accept && !ack_valid)      outstanding_next = outstanding + 4'd1;
            else if (!stb_accept && ack_valid) outstanding_next = outstanding - 4'd1;
            if (i_wb_ack || outstanding == 4'd0) watchdog_next = 16'd0;
            else                                 watchdog_next = watchdog + 16'd1;
        end
    end

    always_comb begin
        o_wb_cyc  = wb_cyc;
        o_wb_stb  = wb_stb;
        o_wb_we   = 1'b0;
        o_wb_addr = '0;
        o_wb_data = '0;
        o_wb_be   = '0;
        case (state)
            ST_GRANT_A: begin
                o_wb_we   = i_a_we;
                o_wb_addr = i_a_addr;
                o_wb_data = i_a_data;
                o_wb_be   = i_a_be;
            end
            ST_GRANT_B: begin
                o_wb_addr = i_b_addr;
                o_wb_be   = '1;
            end
            default: ;
        endcase

        o_a_stall = (state == ST_GRANT_A) ? (i_wb_stall || out_full) : 1'b1;
        o_b_stall = (state == ST_GRANT_B) ? (i_wb_stall || out_full) : 1'b1;
        o_a_ack   = (state == ST_GRANT_A) && ack_valid;
        o_b_ack   = (state == ST_GRANT_B) && ack_valid;
        o_a_err   = (state == ST_GRANT_A) && abort;
        o_b_err   = (state == ST_GRANT_B) && abort;
        o_a_data  = i_wb_data;
        o_b_data  = i_wb_data;
        o_grant   = state;
    end

endmodule
